// File: rtl/display_status_formatter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// display_status_formatter_pkg : shared states, digit positions and display constants
// Revision 1.0
// ----------------------------------------------------------------------------
package display_status_formatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } fmt_state_t;

  localparam logic [15:0] FIXED_BLANK_DEFAULT = 16'h4A80;
  localparam int unsigned BLINK_DIV_DEFAULT   = 6750000;

  localparam int unsigned DIG_FSM     = 15;
  localparam int unsigned DIG_TENS    = 13;
  localparam int unsigned DIG_ONES    = 12;
  localparam int unsigned DIG_PLAY    = 10;
  localparam int unsigned DIG_SONG    = 8;
  localparam int unsigned EFFECT_BITS = 28;

  // Dot-matrix driver shifts one column every 40 system clocks.
  localparam int unsigned DISP_CLK_DIV  = 40;
  localparam int unsigned DISP_CLK_HALF = DISP_CLK_DIV / 2;

  localparam logic [7:0] SECONDS_MAX = 8'd99;

  function automatic logic [7:0] clamp_seconds(input logic [7:0] s);
    return (s > SECONDS_MAX) ? SECONDS_MAX : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_status_formatter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// display_status_formatter_if : status inputs and driver-facing outputs
// Revision 1.0
// ----------------------------------------------------------------------------
interface display_status_formatter_if;
  logic        load;
  logic [1:0]  fsm_state;
  logic [7:0]  seconds;
  logic        play_record;
  logic [3:0]  song_choice;
  logic [27:0] effect_nums;
  logic [3:0]  cursor;
  logic        cursor_en;
  logic [63:0] data;
  logic [15:0] blank_data;
  logic [15:0] blink_data;
  logic        busy;

  modport master (
    output load, fsm_state, seconds, play_record, song_choice, effect_nums,
           cursor, cursor_en,
    input  data, blank_data, blink_data, busy
  );

  modport slave (
    input  load, fsm_state, seconds, play_record, song_choice, effect_nums,
           cursor, cursor_en,
    output data, blank_data, blink_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/display_status_formatter_bin2bcd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// display_status_formatter_bin2bcd_seq : 8-cycle shift-add-3 binary to 2-digit BCD
// Revision 1.0
// ----------------------------------------------------------------------------
module display_status_formatter_bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Upper byte accumulates BCD; input is pre-clamped to 0..99 so no hundreds digit.
  logic [15:0] sr;
  logic [15:0] sr_adj;
  logic [2:0]  cnt;
  logic        running;

  always_comb begin
    sr_adj = sr;
    if (sr[11:8] >= 4'd5)  sr_adj[11:8]  = sr[11:8]  + 4'd3;
    if (sr[15:12] >= 4'd5) sr_adj[15:12] = sr[15:12] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      sr      <= {8'h00, bin};
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      sr  <= {sr_adj[14:0], 1'b0};
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) running <= 1'b0;
    end
  end

  // Asserted during the cycle whose closing edge performs the final shift.
  assign done = running && (cnt == 3'd7);
  assign tens = sr[15:12];
  assign ones = sr[11:8];

endmodule
`default_nettype wire

// File: rtl/display_status_formatter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// display_status_formatter : builds the dot-matrix digit image, blank and blink masks
// Revision 1.0
// ----------------------------------------------------------------------------
module display_status_formatter
  import display_status_formatter_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = BLINK_DIV_DEFAULT,
  parameter logic [15:0] FIXED_BLANK = FIXED_BLANK_DEFAULT
) (
  input  logic                       clock_27mhz,
  input  logic                       reset_b,
  display_status_formatter_if.slave  bus
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  fmt_state_t  state, state_nxt;
  logic        pending, pending_nxt;
  logic        capture, commit;
  logic        conv_done;
  logic [3:0]  tens, ones;

  logic [1:0]  sh_fsm_state;
  logic        sh_play_record;
  logic [3:0]  sh_song_choice;
  logic [EFFECT_BITS-1:0] sh_effect_nums;

  logic [63:0] image;
  logic [63:0] data_q;
  logic [15:0] blank_q;

  logic [CNT_W-1:0] blink_cnt;
  logic        blink_phase;
  logic [15:0] blink_nxt, blink_q;

  display_status_formatter_bin2bcd_seq u_bin2bcd_seq (
    .clk   (clock_27mhz),
    .rst_n (reset_b),
    .start (capture),
    .bin   (clamp_seconds(bus.seconds)),
    .done  (conv_done),
    .tens  (tens),
    .ones  (ones)
  );

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    capture     = 1'b0;
    commit      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.load) begin
          capture   = 1'b1;
          state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (bus.load) pending_nxt = 1'b1;
        if (conv_done) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        // A load landing on the commit edge is folded into the recapture.
        commit      = 1'b1;
        pending_nxt = 1'b0;
        if (pending || bus.load) begin
          capture   = 1'b1;
          state_nxt = ST_CONVERT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      sh_fsm_state   <= '0;
      sh_play_record <= 1'b0;
      sh_song_choice <= '0;
      sh_effect_nums <= '0;
    end else if (capture) begin
      sh_fsm_state   <= bus.fsm_state;
      sh_play_record <= bus.play_record;
      sh_song_choice <= bus.song_choice;
      sh_effect_nums <= bus.effect_nums;
    end
  end

  always_comb begin
    image                       = '0;
    image[DIG_FSM*4 +: 4]       = {2'b00, sh_fsm_state};
    image[DIG_TENS*4 +: 4]      = tens;
    image[DIG_ONES*4 +: 4]      = ones;
    image[DIG_PLAY*4 +: 4]      = {3'b000, sh_play_record};
    image[DIG_SONG*4 +: 4]      = sh_song_choice;
    image[EFFECT_BITS-1:0]      = sh_effect_nums;
  end

  // Image and blank mask update on the same edge so the driver never sees a torn frame.
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      data_q  <= '0;
      blank_q <= 16'hFFFF;
    end else if (commit) begin
      data_q  <= image;
      blank_q <= FIXED_BLANK;
    end
  end

  always_comb begin
    blink_nxt = '0;
    if (bus.cursor_en && blink_phase && !FIXED_BLANK[bus.cursor])
      blink_nxt = 16'h0001 << bus.cursor;
  end

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_q     <= '0;
    end else begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      blink_q <= blink_nxt;
    end
  end

  assign bus.data       = data_q;
  assign bus.blank_data = blank_q;
  assign bus.blink_data = blink_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_display_status_formatter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_display_status_formatter : vector table + scoreboard bench for the formatter
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_display_status_formatter;

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  sec;
    logic        pr;
    logic [3:0]  song;
    logic [27:0] eff;
    logic [63:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [63:0] exp_q[$];
  vec_t vecs[8];

  display_status_formatter_if bus();

  display_status_formatter #(.BLINK_DIV(4)) dut (
    .clock_27mhz (clk),
    .reset_b     (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty scoreboard want an entry", name);
    end else begin
      check(name, bus.data, exp_q.pop_front());
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive_fields(input vec_t v);
    bus.fsm_state   = v.st;
    bus.seconds     = v.sec;
    bus.play_record = v.pr;
    bus.song_choice = v.song;
    bus.effect_nums = v.eff;
  endtask

  // Called on a negedge; returns on the negedge just after the load edge N.
  task automatic pulse_load(input vec_t v);
    drive_fields(v);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    exp_q.push_back(v.exp_data);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int nbusy;
    nbusy = 0;
    pulse_load(v);
    bus.fsm_state   = 2'($urandom);
    bus.seconds     = 8'($urandom);
    bus.play_record = 1'($urandom);
    bus.song_choice = 4'($urandom);
    bus.effect_nums = 28'($urandom);
    for (int i = 0; i < 9; i++) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(nbusy), 64'd9);
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    pop_check({name, "_data"});
    check({name, "_blank"}, 64'(bus.blank_data), 64'h4A80);
  endtask

  initial begin
    logic [15:0] s[28];
    logic [15:0] acc;
    logic [15:0] expv;
    logic [63:0] last_data;
    int t;
    bit found;

    vecs[0] = '{2'd2, 8'd47,  1'b1, 4'h5, 28'h1234567, 64'h2047_0105_0123_4567};
    vecs[1] = '{2'd1, 8'd200, 1'b0, 4'hA, 28'h7654321, 64'h1099_000A_0765_4321};
    vecs[2] = '{2'd3, 8'd0,   1'b1, 4'hF, 28'hFFFFFFF, 64'h3000_010F_0FFF_FFFF};
    vecs[3] = '{2'd0, 8'd99,  1'b0, 4'h0, 28'h0000000, 64'h0099_0000_0000_0000};
    vecs[4] = '{2'd2, 8'd9,   1'b1, 4'h3, 28'h0ABCDEF, 64'h2009_0103_00AB_CDEF};
    vecs[5] = '{2'd1, 8'd100, 1'b0, 4'h9, 28'h0000001, 64'h1099_0009_0000_0001};
    vecs[6] = '{2'd0, 8'd59,  1'b1, 4'h1, 28'h1111111, 64'h0059_0101_0111_1111};
    vecs[7] = '{2'd3, 8'd255, 1'b0, 4'h6, 28'h0000000, 64'h3099_0006_0000_0000};

    bus.load = 1'b0;
    bus.cursor = 4'd0;
    bus.cursor_en = 1'b0;
    drive_fields(vecs[3]);
    wait_neg(2);
    rst_n = 1'b1;

    // Idle after reset: dark display, nothing happening.
    for (int k = 0; k < 3; k++) begin
      wait_neg(7);
      check("idle_data", bus.data, 64'h0);
      check("idle_blank", 64'(bus.blank_data), 64'hFFFF);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_blink", 64'(bus.blink_data), 64'h0);
    end

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Load at N, reload at N+3, then two collapsing loads during the second pass.
    begin
      vec_t b, c;
      b = '{2'd1, 8'd12, 1'b0, 4'h2, 28'h0000012, 64'h1012_0002_0000_0012};
      c = '{2'd3, 8'd30, 1'b1, 4'h7, 28'h3030303, 64'h3030_0107_0303_0303};
      pulse_load(vecs[0]);
      wait_neg(2);
      pulse_load(b);
      wait_neg(6);
      check("reload_busy_n9", 64'(bus.busy), 64'd1);
      pop_check("reload_first");
      wait_neg(1);
      drive_fields(c);
      bus.load = 1'b1;
      wait_neg(2);
      bus.load = 1'b0;
      exp_q.push_back(c.exp_data);
      wait_neg(6);
      check("reload_busy_n18", 64'(bus.busy), 64'd1);
      pop_check("reload_second");
      wait_neg(9);
      pop_check("reload_third");
      check("reload_idle_n27", 64'(bus.busy), 64'd0);
      last_data = bus.data;
      wait_neg(12);
      check("reload_no_extra_busy", 64'(bus.busy), 64'd0);
      check("reload_no_extra_data", bus.data, c.exp_data);
      check("reload_last_stable", bus.data, last_data);
    end

    // Load arriving on the commit edge triggers a further pass.
    pulse_load(vecs[4]);
    wait_neg(8);
    pulse_load(vecs[2]);
    check("commit_load_busy", 64'(bus.busy), 64'd1);
    pop_check("commit_load_first");
    wait_neg(9);
    pop_check("commit_load_second");
    check("commit_load_idle", 64'(bus.busy), 64'd0);

    // Blink: cursor 3 toggles 0000/0008 every 4 cycles.
    bus.cursor = 4'd3;
    bus.cursor_en = 1'b1;
    wait_neg(1);
    for (int k = 0; k < 28; k++) begin
      s[k] = bus.blink_data;
      @(negedge clk);
    end
    t = 0;
    for (int k = 1; k < 9; k++) if (t == 0 && s[k] !== s[k-1]) t = k;
    if (t == 0) begin
      total++;
      bad++;
      $display("FAIL blink_toggle: got no transition want toggle within 8 cycles");
    end else begin
      check("blink_value", 64'(s[t] & 16'hFFF7), 64'h0);
      for (int k = t + 1; k < t + 16; k++) begin
        expv = ((((k - t) / 4) % 2) == 0) ? s[t] : (s[t] ^ 16'h0008);
        check($sformatf("blink_seq%0d", k), 64'(s[k]), 64'(expv));
      end
    end

    bus.cursor = 4'd14;
    wait_neg(1);
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      acc = acc | bus.blink_data;
      @(negedge clk);
    end
    check("blink_fixed_blank", 64'(acc), 64'h0);

    bus.cursor = 4'd3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      expv = bus.blink_data;
      @(negedge clk);
      if (expv == 16'h0000 && bus.blink_data == 16'h0008) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL blink_rise: got timeout want 0000->0008 within 20 cycles");
    end else begin
      bus.cursor = 4'd5;
      @(negedge clk);
      check("blink_cursor_move", 64'(bus.blink_data), 64'h0020);
      bus.cursor_en = 1'b0;
      @(negedge clk);
      check("blink_disable", 64'(bus.blink_data), 64'h0);
    end

    // Asynchronous reset in the middle of a conversion.
    bus.cursor_en = 1'b1;
    bus.cursor = 4'd3;
    pulse_load(vecs[6]);
    wait_neg(2);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_data", bus.data, 64'h0);
    check("rst_blank", 64'(bus.blank_data), 64'hFFFF);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_blink", 64'(bus.blink_data), 64'h0);
    void'(exp_q.pop_back());
    bus.cursor_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      acc[0] = acc[0] | bus.busy;
    end
    check("post_rst_busy", 64'(acc), 64'h0);
    check("post_rst_data", bus.data, 64'h0);
    check("post_rst_blank", 64'(bus.blank_data), 64'hFFFF);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
